// File: rtl/move_sequencer_pkg.sv
// Shared definitions for the move sequencer: FSM states, move key codes,
// default timing/limit parameters and the move-code decode.
package move_sequencer_pkg;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_PLAY = 3'd1,
      ST_COOL = 3'd2,
      ST_WIN  = 3'd3,
      ST_LOSE = 3'd4
   } state_t;

   localparam logic [3:0] KEY_DOWN  = 4'h2;
   localparam logic [3:0] KEY_LEFT  = 4'h4;
   localparam logic [3:0] KEY_RIGHT = 4'h6;
   localparam logic [3:0] KEY_UP    = 4'h8;

   localparam int unsigned DEF_DEBOUNCE_CYCLES = 16;
   localparam int unsigned DEF_COOLDOWN_CYCLES = 8;
   localparam int unsigned DEF_MOVE_LIMIT      = 40;
   localparam logic [4:0]  DEF_GOAL_ADDR       = 5'd0;

   function automatic logic is_move_code(input logic [3:0] code);
      return (code == KEY_DOWN) || (code == KEY_LEFT) ||
             (code == KEY_RIGHT) || (code == KEY_UP);
   endfunction

endpackage

// File: rtl/move_sequencer_if.sv
// Keypad/datapath-facing signal bundle of the move sequencer.
interface move_sequencer_if;
   logic [3:0] key_code_i;
   logic       key_valid_i;
   logic       start_i;
   logic [4:0] address_i;
   logic [3:0] key_o;
   logic       enable_move_o;
   logic [2:0] state_o;
   logic [7:0] moves_o;
   logic       win_o;
   logic       lose_o;

   modport master (
      output key_code_i, key_valid_i, start_i, address_i,
      input  key_o, enable_move_o, state_o, moves_o, win_o, lose_o
   );

   modport slave (
      input  key_code_i, key_valid_i, start_i, address_i,
      output key_o, enable_move_o, state_o, moves_o, win_o, lose_o
   );
endinterface

// File: rtl/move_sequencer_key_debouncer.sv
// Synchronises the raw keypad level/code and emits one press per stable key
// hold; a fresh press needs the key released for a full window first.
module key_debouncer
   import move_sequencer_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
   input  logic       clk_50MHz_i,
   input  logic       rst_async_la_i,
   input  logic [3:0] key_code_i,
   input  logic       key_valid_i,
   output logic       press_o,
   output logic [3:0] code_o
);

   localparam int unsigned    CW  = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CW-1:0]  LIM = CW'(DEBOUNCE_CYCLES);

   logic          valid_meta, valid_sync;
   logic [3:0]    code_meta, code_sync, code_ref;
   logic [CW-1:0] hi_cnt, hi_nxt, lo_cnt, lo_nxt;
   logic          armed;

   // Two-flop synchronisers for the asynchronous keypad inputs.
   always_ff @(posedge clk_50MHz_i or negedge rst_async_la_i) begin
      if (!rst_async_la_i) begin
         valid_meta <= 1'b0;
         valid_sync <= 1'b0;
         code_meta  <= '0;
         code_sync  <= '0;
      end else begin
         valid_meta <= key_valid_i;
         valid_sync <= valid_meta;
         code_meta  <= key_code_i;
         code_sync  <= code_meta;
      end
   end

   // Next values of the stable-high and stable-low run counters.
   always_comb begin
      hi_nxt = '0;
      lo_nxt = '0;
      if (valid_sync) begin
         if ((hi_cnt != '0) && (code_sync != code_ref)) begin
            hi_nxt = CW'(1);
         end else if (hi_cnt != LIM) begin
            hi_nxt = hi_cnt + 1'b1;
         end else begin
            hi_nxt = LIM;
         end
      end else if (!armed) begin
         lo_nxt = lo_cnt + 1'b1;
      end
   end

   assign press_o = armed && (hi_nxt == LIM);
   assign code_o  = code_sync;

   // Run counters and the release-rearm flag; a press disarms until release.
   always_ff @(posedge clk_50MHz_i or negedge rst_async_la_i) begin
      if (!rst_async_la_i) begin
         hi_cnt   <= '0;
         lo_cnt   <= '0;
         code_ref <= '0;
         armed    <= 1'b1;
      end else begin
         hi_cnt   <= hi_nxt;
         lo_cnt   <= (lo_nxt == LIM) ? '0 : lo_nxt;
         code_ref <= code_sync;
         if (press_o) begin
            armed <= 1'b0;
         end else if (lo_nxt == LIM) begin
            armed <= 1'b1;
         end
      end
   end

endmodule

// File: rtl/move_sequencer.sv
// Game move sequencer: turns debounced keypad presses into single move
// strobes, enforces a cooldown between moves and tracks win/lose.
module move_sequencer
   import move_sequencer_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
   parameter int unsigned COOLDOWN_CYCLES = DEF_COOLDOWN_CYCLES,
   parameter int unsigned MOVE_LIMIT      = DEF_MOVE_LIMIT,
   parameter logic [4:0]  GOAL_ADDR       = DEF_GOAL_ADDR
) (
   input  logic           clk_50MHz_i,
   input  logic           rst_async_la_i,
   move_sequencer_if.slave bus
);

   localparam int unsigned    CCW       = $clog2(COOLDOWN_CYCLES);
   localparam logic [CCW-1:0] COOL_LAST = CCW'(COOLDOWN_CYCLES - 1);
   localparam logic [7:0]     LIMIT_C   = 8'(MOVE_LIMIT);

   state_t         state, state_nxt;
   logic [CCW-1:0] cool_cnt;
   logic           press;
   logic [3:0]     code;
   logic           issue, clear;
   logic [3:0]     key;
   logic           enable;
   logic [7:0]     moves;
   logic           win, lose;

   key_debouncer #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
   ) u_key_debouncer (
      .clk_50MHz_i    (clk_50MHz_i),
      .rst_async_la_i (rst_async_la_i),
      .key_code_i     (bus.key_code_i),
      .key_valid_i    (bus.key_valid_i),
      .press_o        (press),
      .code_o         (code)
   );

   // FSM state register.
   always_ff @(posedge clk_50MHz_i or negedge rst_async_la_i) begin
      if (!rst_async_la_i) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state decode plus issue/clear strobes for the datapath registers.
   always_comb begin
      state_nxt = state;
      issue     = 1'b0;
      clear     = 1'b0;
      unique case (state)
         ST_IDLE, ST_WIN, ST_LOSE: begin
            if (bus.start_i) begin
               clear     = 1'b1;
               state_nxt = ST_PLAY;
            end
         end
         ST_PLAY: begin
            if (press && is_move_code(code)) begin
               issue     = 1'b1;
               state_nxt = ST_COOL;
            end
         end
         ST_COOL: begin
            if (cool_cnt == '0) begin
               if (bus.address_i == GOAL_ADDR) begin
                  state_nxt = ST_WIN;
               end else if (moves == LIMIT_C) begin
                  state_nxt = ST_LOSE;
               end else begin
                  state_nxt = ST_PLAY;
               end
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // Move strobe, held key, cooldown and saturating move counter; win/lose
   // are decoded from the next state so they line up with state_o.
   always_ff @(posedge clk_50MHz_i or negedge rst_async_la_i) begin
      if (!rst_async_la_i) begin
         cool_cnt <= '0;
         key      <= '0;
         enable   <= 1'b0;
         moves    <= '0;
         win      <= 1'b0;
         lose     <= 1'b0;
      end else begin
         enable <= issue;
         win    <= (state_nxt == ST_WIN);
         lose   <= (state_nxt == ST_LOSE);
         if (issue) begin
            key      <= code;
            cool_cnt <= COOL_LAST;
         end else if ((state == ST_COOL) && (cool_cnt != '0)) begin
            cool_cnt <= cool_cnt - 1'b1;
         end
         if (clear) begin
            moves <= '0;
         end else if (issue && (moves != 8'hFF)) begin
            moves <= moves + 8'd1;
         end
      end
   end

   assign bus.key_o         = key;
   assign bus.enable_move_o = enable;
   assign bus.state_o       = state;
   assign bus.moves_o       = moves;
   assign bus.win_o         = win;
   assign bus.lose_o        = lose;

endmodule

// File: tb/tb_move_sequencer.sv
// Self-checking bench for move_sequencer: directed vectors, multi-cycle
// corner sequences and random presses against a window-based reference model.
module tb_move_sequencer;

   localparam int         DEB   = 16;
   localparam int         COOL  = 8;
   localparam int         LIMIT = 40;
   localparam logic [4:0] GOAL  = 5'd0;
   localparam logic [4:0] AWAY  = 5'd7;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #10 clk = ~clk;

   move_sequencer_if bus();

   move_sequencer #(
      .DEBOUNCE_CYCLES(DEB),
      .COOLDOWN_CYCLES(COOL),
      .MOVE_LIMIT(LIMIT),
      .GOAL_ADDR(GOAL)
   ) dut (
      .clk_50MHz_i    (clk),
      .rst_async_la_i (rst_n),
      .bus            (bus)
   );

   int checks = 0;
   int errors = 0;
   int pulses = 0;
   bit chk_en = 0;

   // Reference model state (state numbers as listed for the block: 0..4)
   int         m_state;
   logic [3:0] m_key;
   bit         m_en;
   int         m_moves;
   int         m_cool_left;
   bit         m_armed;
   bit         p1_v, p2_v;
   logic [3:0] p1_c, p2_c;
   bit         wv[$];
   logic [3:0] wc[$];

   logic [17:0] act_v, exp_v;

   task automatic model_reset();
      m_state = 0; m_key = '0; m_en = 0; m_moves = 0; m_cool_left = 0; m_armed = 1;
      p1_v = 0; p2_v = 0; p1_c = '0; p2_c = '0;
      wv.delete(); wc.delete();
      for (int i = 0; i < DEB; i++) begin
         wv.push_back(1'b0);
         wc.push_back(4'h0);
      end
   endtask

   task automatic model_step();
      bit sv, all_hi, all_lo, accept;
      logic [3:0] sc;
      sv = p2_v; sc = p2_c;
      p2_v = p1_v; p2_c = p1_c;
      p1_v = bus.key_valid_i; p1_c = bus.key_code_i;
      wv.push_back(sv); wc.push_back(sc);
      if (wv.size() > DEB) begin
         void'(wv.pop_front());
         void'(wc.pop_front());
      end
      all_hi = 1; all_lo = 1;
      foreach (wv[i]) begin
         if (wv[i]) all_lo = 0; else all_hi = 0;
         if (wc[i] != sc) all_hi = 0;
      end
      accept = 0;
      if (m_armed && all_hi) begin
         accept = 1; m_armed = 0;
      end else if (!m_armed && all_lo) begin
         m_armed = 1;
      end
      m_en = 0;
      case (m_state)
         0, 3, 4: if (bus.start_i) begin m_moves = 0; m_state = 1; end
         1: if (accept && (sc inside {4'h2, 4'h4, 4'h6, 4'h8})) begin
               m_key = sc; m_en = 1;
               if (m_moves < 255) m_moves++;
               m_state = 2; m_cool_left = COOL;
            end
         2: begin
               m_cool_left--;
               if (m_cool_left == 0) begin
                  if (bus.address_i == GOAL)   m_state = 3;
                  else if (m_moves == LIMIT)   m_state = 4;
                  else                         m_state = 1;
               end
            end
         default: ;
      endcase
   endtask

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) model_reset();
      else        model_step();
   end

   always @(negedge clk) begin
      if (bus.enable_move_o) pulses++;
      if (chk_en) begin
         act_v = {bus.state_o, bus.key_o, bus.enable_move_o, bus.moves_o, bus.win_o, bus.lose_o};
         exp_v = {3'(m_state), m_key, m_en, 8'(m_moves), (m_state == 3), (m_state == 4)};
         checks++;
         if (act_v !== exp_v) begin
            errors++;
            $display("FAIL cycle @%0t: {state,key,en,moves,win,lose} got %h expected %h", $time, act_v, exp_v);
         end
      end
   end

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s @%0t: got %0d expected %0d", name, $time, act, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic press(input logic [3:0] c, input int hold, input int rel);
      @(negedge clk);
      bus.key_code_i = c; bus.key_valid_i = 1'b1;
      cyc(hold);
      bus.key_valid_i = 1'b0;
      cyc(rel);
   endtask

   task automatic start_pulse();
      @(negedge clk); bus.start_i = 1'b1;
      @(negedge clk); bus.start_i = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clk); #3 rst_n = 1'b0;
      cyc(2); #3 rst_n = 1'b1;
   endtask

   // Holds a key until the strobe appears (bounded), then drives addr
   // through the cooldown and waits long enough to rearm.
   task automatic issue_move(input logic [3:0] c, input logic [4:0] addr, output bit ok);
      ok = 0;
      @(negedge clk);
      bus.key_code_i = c; bus.key_valid_i = 1'b1;
      for (int i = 0; i < 40 && !ok; i++) begin
         @(negedge clk);
         if (bus.enable_move_o) ok = 1;
      end
      bus.address_i = addr; bus.key_valid_i = 1'b0;
      cyc(30);
      bus.address_i = AWAY;
   endtask

   typedef struct {
      logic [3:0] code;
      int         hold;
      int         exp_pulses;
      logic [3:0] exp_key;
      int         exp_moves;
   } vec_t;

   vec_t vecs[6];

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got no completion, expected finish before 2 ms");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int p0, first, n_ok;
      bit ok;
      vecs[0] = '{4'h5, 30, 0, 4'h2, 1};
      vecs[1] = '{4'hF, 30, 0, 4'h2, 1};
      vecs[2] = '{4'h4, 15, 0, 4'h2, 1};
      vecs[3] = '{4'h4, 16, 1, 4'h4, 2};
      vecs[4] = '{4'h8, 30, 1, 4'h8, 3};
      vecs[5] = '{4'h6, 40, 1, 4'h6, 4};

      bus.key_code_i = '0; bus.key_valid_i = 1'b0; bus.start_i = 1'b0; bus.address_i = AWAY;
      model_reset();
      cyc(3); #3 rst_n = 1'b1;
      chk_en = 1;

      check("rst_state", int'(bus.state_o), 0);
      check("rst_key",   int'(bus.key_o), 0);
      check("rst_en",    int'(bus.enable_move_o), 0);
      check("rst_moves", int'(bus.moves_o), 0);
      check("rst_win",   int'(bus.win_o), 0);
      check("rst_lose",  int'(bus.lose_o), 0);

      // Start plus a long hold issues exactly one move
      start_pulse();
      check("start_state", int'(bus.state_o), 1);
      p0 = pulses;
      press(4'h2, 100, 40);
      check("hold_pulses", pulses - p0, 1);
      check("hold_key",    int'(bus.key_o), 2);
      check("hold_moves",  int'(bus.moves_o), 1);
      check("hold_state",  int'(bus.state_o), 1);

      // Directed vector table
      foreach (vecs[i]) begin
         p0 = pulses;
         press(vecs[i].code, vecs[i].hold, 40);
         check($sformatf("vec%0d_pulses", i), pulses - p0, vecs[i].exp_pulses);
         check($sformatf("vec%0d_key", i),    int'(bus.key_o), int'(vecs[i].exp_key));
         check($sformatf("vec%0d_moves", i),  int'(bus.moves_o), vecs[i].exp_moves);
      end

      // Non-move press, then code change without release: no move
      p0 = pulses;
      @(negedge clk); bus.key_code_i = 4'h5; bus.key_valid_i = 1'b1;
      cyc(30); bus.key_code_i = 4'h2;
      cyc(30); bus.key_valid_i = 1'b0;
      cyc(40);
      check("norelease_pulses", pulses - p0, 0);
      check("norelease_moves",  int'(bus.moves_o), 4);

      // Bounce then stable hold: one move, 16 stable clocks + 2 sync clocks
      p0 = pulses;
      @(negedge clk); bus.key_code_i = 4'h8;
      for (int s = 0; s < 12; s++) begin
         bus.key_valid_i = (s % 2 == 0);
         cyc(5);
      end
      bus.key_valid_i = 1'b1; first = -1;
      for (int i = 1; i <= 20; i++) begin
         @(negedge clk);
         if (bus.enable_move_o && first < 0) first = i;
      end
      bus.key_valid_i = 1'b0;
      cyc(40);
      check("bounce_pulses",  pulses - p0, 1);
      check("bounce_latency", first, 18);

      // Random presses against the reference model
      for (int it = 0; it < 60; it++) begin
         logic [3:0] c;
         if ($urandom_range(0, 9) == 0) start_pulse();
         bus.address_i = ($urandom_range(0, 7) == 0) ? GOAL : 5'($urandom_range(1, 31));
         case ($urandom_range(0, 4))
            0: c = 4'h2;
            1: c = 4'h4;
            2: c = 4'h6;
            3: c = 4'h8;
            default: c = 4'($urandom);
         endcase
         press(c, $urandom_range(1, 40), $urandom_range(1, 40));
      end
      bus.address_i = AWAY;

      // Goal reached during cooldown: win, no further moves, restart clears
      do_reset();
      start_pulse();
      issue_move(4'h2, GOAL, ok);
      check("win_issue", int'(ok), 1);
      check("win_state", int'(bus.state_o), 3);
      check("win_flag",  int'(bus.win_o), 1);
      check("win_lose",  int'(bus.lose_o), 0);
      p0 = pulses;
      press(4'h4, 30, 40);
      check("win_nomove", pulses - p0, 0);
      start_pulse();
      check("restart_state", int'(bus.state_o), 1);
      check("restart_moves", int'(bus.moves_o), 0);
      check("restart_win",   int'(bus.win_o), 0);

      // Move limit: lose after the 40th cooldown
      n_ok = 0;
      for (int i = 0; i < LIMIT; i++) begin
         issue_move(4'h6, AWAY, ok);
         n_ok += int'(ok);
      end
      check("lose_issued", n_ok, LIMIT);
      check("lose_state",  int'(bus.state_o), 4);
      check("lose_flag",   int'(bus.lose_o), 1);
      check("lose_win",    int'(bus.win_o), 0);
      check("lose_moves",  int'(bus.moves_o), LIMIT);

      // Goal and limit on the same cooldown: win has priority
      start_pulse();
      n_ok = 0;
      for (int i = 0; i < LIMIT - 1; i++) begin
         issue_move(4'h4, AWAY, ok);
         n_ok += int'(ok);
      end
      issue_move(4'h8, GOAL, ok);
      n_ok += int'(ok);
      check("tie_issued", n_ok, LIMIT);
      check("tie_state",  int'(bus.state_o), 3);
      check("tie_win",    int'(bus.win_o), 1);
      check("tie_lose",   int'(bus.lose_o), 0);

      // Reset on cooldown cycle 3, key kept held across reset
      do_reset();
      start_pulse();
      @(negedge clk); bus.key_code_i = 4'h2; bus.key_valid_i = 1'b1;
      ok = 0;
      for (int i = 0; i < 40 && !ok; i++) begin
         @(negedge clk);
         if (bus.enable_move_o) ok = 1;
      end
      check("midcool_issue", int'(ok), 1);
      cyc(2);
      check("midcool_state", int'(bus.state_o), 2);
      #3 rst_n = 1'b0;
      #1;
      check("midrst_state", int'(bus.state_o), 0);
      check("midrst_key",   int'(bus.key_o), 0);
      check("midrst_en",    int'(bus.enable_move_o), 0);
      check("midrst_moves", int'(bus.moves_o), 0);
      check("midrst_win",   int'(bus.win_o), 0);
      check("midrst_lose",  int'(bus.lose_o), 0);
      @(negedge clk); #3 rst_n = 1'b1;
      cyc(2);
      check("postrst_state", int'(bus.state_o), 0);
      p0 = pulses;
      start_pulse();
      cyc(40);
      bus.key_valid_i = 1'b0;
      cyc(40);
      check("postrst_pulses", pulses - p0, 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/move_sequencer.md
MOVE_SEQUENCER -- requirements
Module: move_sequencer

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_CYCLES, default 16, meaning the number of clocks a raw key level must hold stable to be accepted.
REQ-002 The block SHALL have parameter COOLDOWN_CYCLES, default 8 (legal minimum 4), meaning the number of clocks between an issued move and the next accepted move.
REQ-003 The block SHALL have parameter MOVE_LIMIT, default 40, meaning the number of issued moves after which the game is lost.
REQ-004 The block SHALL have parameter GOAL_ADDR, default 5'd0, meaning the winning {posy,posx} address.
REQ-005 The port clk_50MHz_i SHALL be an input, 1 bit wide: the system clock.
REQ-006 The port rst_async_la_i SHALL be an input, 1 bit wide: the reset, asynchronous, active-low.
REQ-007 The port key_code_i SHALL be an input, 4 bits wide: the raw keypad code (asynchronous).
REQ-008 The port key_valid_i SHALL be an input, 1 bit wide: the raw key-pressed level (asynchronous).
REQ-009 The port start_i SHALL be an input, 1 bit wide: a synchronous start/restart pulse.
REQ-010 The port address_i SHALL be an input, 5 bits wide: the current player address from the position datapath.
REQ-011 The port key_o SHALL be an output, 4 bits wide: the held direction code for the position datapath.
REQ-012 The port enable_move_o SHALL be an output, 1 bit wide: a one-cycle move strobe.
REQ-013 The port state_o SHALL be an output, 3 bits wide: the current FSM state.
REQ-014 The port moves_o SHALL be an output, 8 bits wide: the count of issued moves.
REQ-015 The port win_o SHALL be an output, 1 bit wide: high in WIN.
REQ-016 The port lose_o SHALL be an output, 1 bit wide: high in LOSE.

Function
REQ-017 key_valid_i and key_code_i SHALL each pass through a 2-flop synchronizer before any use.
REQ-018 A press SHALL be accepted when the synchronized valid has been high with an unchanged code for DEBOUNCE_CYCLES consecutive clocks.
- A code change during this window restarts the count.
REQ-019 After an accepted press, no further press SHALL be accepted until the synchronized valid has been low for DEBOUNCE_CYCLES consecutive clocks.
- Holding a key issues exactly one move.
REQ-020 Only codes 4'h2, 4'h4, 4'h6 and 4'h8 SHALL be move codes.
- Other accepted codes are discarded, but still require release before the next press.
REQ-021 The FSM SHALL have states IDLE=0, PLAY=1, COOL=2, WIN=3, LOSE=4.
REQ-022 In IDLE, WIN or LOSE, start_i SHALL clear moves_o to 0 and move the FSM to PLAY on the next clock.
- start_i is ignored in PLAY and COOL.
REQ-023 In PLAY, an accepted move code SHALL, on the same clock edge:
- load key_o with the code;
- assert enable_move_o for exactly one cycle;
- increment moves_o;
- enter COOL.
REQ-024 key_o SHALL hold its value until the next issued move, so it remains stable through the 2-clock datapath latency.
REQ-025 Presses accepted outside PLAY SHALL be discarded and SHALL NOT be queued.
REQ-026 COOL SHALL last exactly COOLDOWN_CYCLES clocks.
REQ-027 On the final COOL cycle, the FSM SHALL go:
- to WIN if address_i == GOAL_ADDR;
- else to LOSE if moves_o == MOVE_LIMIT;
- else to PLAY.
- WIN has priority over LOSE.
REQ-028 Moves blocked by walls or bounds in the datapath SHALL still count.
REQ-029 moves_o SHALL saturate at 8'hFF.
REQ-030 win_o and lose_o SHALL be registered decodes of the state, and never both high.
REQ-031 enable_move_o SHALL be 0 in every state except on the issuing PLAY cycle.

Reset
REQ-032 Asserting reset SHALL asynchronously force the following values, at any time including mid-COOL or mid-debounce:
- state IDLE;
- key_o 4'h0;
- enable_move_o 0;
- moves_o 0;
- win_o 0;
- lose_o 0;
- synchronizers and debounce counters cleared.
REQ-033 After reset deassertion, a key already held SHALL need a full DEBOUNCE_CYCLES window before acceptance.

Structure
REQ-034 A shared package SHALL hold the state encodings, the four move key codes, and the default parameter values.
REQ-035 Synchronizer plus debounce SHALL be a sub-module key_debouncer, outputting press_o (1-cycle) and code_o[3:0].
REQ-036 The FSM, cooldown counter and move counter SHALL reside in move_sequencer.

Verification
REQ-037 Start plus a held key SHALL issue one move: reset, start_i pulse, hold code 4'h2 for 100 clocks -> exactly one enable_move_o pulse, key_o=4'h2, moves_o=1, state returns to PLAY.
REQ-038 Bounce SHALL be filtered: toggle valid every 5 clocks for 60 clocks, then hold 20 clocks -> exactly one move, issued on the 16th stable-high clock plus 2-clock sync delay.
REQ-039 Reaching the goal SHALL win: with address_i driven to 5'd0 during COOL -> WIN at COOL end, win_o=1; a further press issues no move; start_i -> PLAY with moves_o=0.
REQ-040 The move limit SHALL lose: 40 accepted moves with address_i != GOAL_ADDR -> LOSE after the 40th COOL, lose_o=1; with goal and limit coinciding -> WIN.
REQ-041 Non-move codes SHALL be ignored: press codes 4'h5 and 4'hF -> no pulse and moves_o unchanged; a new press without release -> rejected.
REQ-042 Reset mid-COOL SHALL clear all state: assert reset on COOL cycle 3 -> all outputs at reset values immediately; after release, state IDLE.
